// File: rtl/im_loader_pkg.sv
// im_loader_pkg -- shared types and constants for the instruction-memory loader.
//   IM_ADDR_W / BYTE_W / WORD_W : IM address, stream byte and IM word widths
//   CNT_W / LEN_W               : word counter and length-header widths
//   MAX_WORDS_DEF               : default IM depth in words
//   state_e                     : loader FSM states (ST_CHK only exists when
//                                 IM_LOADER_CHECKSUM_EN is defined)
package im_loader_pkg;
  localparam int IM_ADDR_W     = 10;
  localparam int BYTE_W        = 8;
  localparam int WORD_W        = 32;
  localparam int CNT_W         = 11;
  localparam int LEN_W         = 16;
  localparam int MAX_WORDS_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
`ifdef IM_LOADER_CHECKSUM_EN
    ST_CHK    = 3'd5,
`endif
    ST_DONE   = 3'd6
  } state_e;
endpackage

// File: rtl/im_loader_if.sv
// im_loader_if -- byte-stream input and IM write bus of the loader.
//   rx_data/rx_valid/rx_ready : inbound program bytes, valid/ready handshake
//   im_we/im_addr/im_wdata    : instruction-memory write port
//   modport master : the loader (consumes bytes, drives IM writes)
//   modport slave  : the byte source / IM side
interface im_loader_if;
  import im_loader_pkg::*;

  logic [BYTE_W-1:0]    rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 im_we;
  logic [IM_ADDR_W-1:0] im_addr;
  logic [WORD_W-1:0]    im_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/im_byte_packer.sv
// im_byte_packer -- packs 4 stream bytes into one 32-bit word, MSB first.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr_i        : restart packing at byte 0 (new load)
//   byte_vld_i   : a data byte is transferred this cycle
//   byte_i       : the transferred byte
//   word_o       : previous 3 bytes plus byte_i (complete when last_o)
//   last_o       : byte_i is the 4th byte of the current word
module im_byte_packer
  import im_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              byte_vld_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              last_o
);
  // Only the first three bytes are stored; the fourth is taken straight
  // from the stream so the word is ready on the handshake cycle.
  logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;
  logic [1:0]               idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clr_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_vld_i) begin
      shift_d = {shift_q[WORD_W-2*BYTE_W-1:0], byte_i};
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign word_o = {shift_q, byte_i};
  assign last_o = byte_vld_i && (idx_q == 2'd3);
endmodule

// File: rtl/im_loader.sv
// im_loader -- loads a length-prefixed byte stream into instruction memory.
// Stream: N[15:8], N[7:0], then N words of 4 bytes (MSB first), then, when
// IM_LOADER_CHECKSUM_EN is defined, one XOR checksum byte over all data bytes.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : one-cycle load request (honoured only in IDLE)
//   bus          : byte stream in, IM write port out (im_loader_if.master)
//   busy         : high whenever not IDLE
//   done         : one-cycle completion pulse
//   err          : sticky error (bad length / bad checksum), cleared on start
//   word_cnt     : words written during the current/last load
// Parameters: BASE_ADDR (first IM word written), MAX_WORDS (IM depth).
module im_loader
  import im_loader_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  im_loader_if.master      bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt
);
  localparam logic [IM_ADDR_W-1:0] BASE_A = IM_ADDR_W'(BASE_ADDR);
  // Largest N that still fits between BASE_ADDR and the top of the IM.
  localparam logic [LEN_W:0]       LIMIT  = (LEN_W+1)'(MAX_WORDS - BASE_ADDR);

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [IM_ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]    wdata_q, wdata_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]    chk_q, chk_d;
`endif

  logic              rx_ready_w;
  logic              hs;
  logic              start_acc;
  logic              pk_vld;
  logic              pk_last;
  logic [WORD_W-1:0] pk_word;
  logic [LEN_W-1:0]  len_full;

  always_comb begin
    rx_ready_w = 1'b0;
    case (state_q)
      ST_LEN_HI, ST_LEN_LO, ST_DATA: rx_ready_w = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
      ST_CHK:                        rx_ready_w = 1'b1;
`endif
      default:                       rx_ready_w = 1'b0;
    endcase
  end

  assign hs        = bus.rx_valid && rx_ready_w;
  assign start_acc = (state_q == ST_IDLE) && start;
  assign pk_vld    = hs && (state_q == ST_DATA);
  assign len_full  = {len_q[LEN_W-1:BYTE_W], bus.rx_data};

  im_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (start_acc),
    .byte_vld_i (pk_vld),
    .byte_i     (bus.rx_data),
    .word_o     (pk_word),
    .last_o     (pk_last)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LEN_HI;
          err_d   = 1'b0;
          cnt_d   = '0;
          len_d   = '0;
`ifdef IM_LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      ST_LEN_HI: begin
        if (hs) begin
          len_d   = {bus.rx_data, len_q[BYTE_W-1:0]};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (hs) begin
          len_d = len_full;
          // Empty or oversize loads finish immediately without writing.
          if ((len_full == '0) || ({1'b0, len_full} > LIMIT)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (hs) begin
`ifdef IM_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ bus.rx_data;
`endif
          if (pk_last) begin
            // Latch the write now so address/data hold after the strobe.
            addr_d  = BASE_A + cnt_q[IM_ADDR_W-1:0];
            wdata_d = pk_word;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (LEN_W'(cnt_d) < len_q) begin
          state_d = ST_DATA;
        end else begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (hs) begin
          if (bus.rx_data != chk_q) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IM_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign bus.rx_ready = rx_ready_w;
  assign bus.im_we    = (state_q == ST_WRITE);
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = wdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign err          = err_q;
  assign word_cnt     = cnt_q;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader -- self-checking bench for im_loader (BASE_ADDR 0, 1024 words).
// Honours IM_LOADER_CHECKSUM_EN: when defined, every good load carries a
// checksum byte and the checksum scenarios are exercised.
`timescale 1ns/1ps
module tb_im_loader;
  import im_loader_pkg::*;

  localparam int TB_BASE = 0;
  localparam int TB_MAX  = 1024;

  typedef logic [7:0] bq_t[$];

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             start   = 1'b0;
  logic             busy, done, err;
  logic [CNT_W-1:0] word_cnt;

  im_loader_if bus ();

  im_loader #(.BASE_ADDR(TB_BASE), .MAX_WORDS(TB_MAX)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed IM writes {addr, data}, sampled mid-cycle.
  logic [41:0] obs_q[$];
  always @(negedge clk) begin
    if (reset_n && bus.im_we) obs_q.push_back({bus.im_addr, bus.im_wdata});
  end

  // Reference results for the load currently being checked.
  logic [41:0] exp_q[$];
  logic        exp_err;
  int          exp_cnt;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Behavioural model: interpret the byte stream by the loader's rules.
  task automatic model(input bq_t s);
    int         n;
    logic [7:0] x;
    logic [31:0] w;
    exp_q.delete();
    exp_err = 1'b0;
    exp_cnt = 0;
    x = 8'h00;
    n = int'(s[0]) * 256 + int'(s[1]);
    if (n == 0 || n > TB_MAX - TB_BASE) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
      x = x ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
      exp_q.push_back({10'(TB_BASE + i), w});
    end
    exp_cnt = n;
`ifdef IM_LOADER_CHECKSUM_EN
    if (s[2+4*n] != x) exp_err = 1'b1;
`endif
  endtask

  // Append the checksum byte (optionally corrupted) when the feature exists.
  task automatic add_chk(input bq_t s, input bit bad, output bq_t r);
    logic [7:0] x;
    r = s;
    x = 8'h00;
    for (int i = 2; i < s.size(); i++) x = x ^ s[i];
`ifdef IM_LOADER_CHECKSUM_EN
    r.push_back(bad ? (x ^ 8'h01) : x);
`endif
  endtask

  task automatic build(input int n, input bit bad, output bq_t r);
    bq_t s;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom_range(255, 0)));
    add_chk(s, bad, r);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int t;
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (poke) start = 1'b1;
    t = 0;
    while (bus.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rx_ready_timeout", 32'(t < 50), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_load(input string tag, input bq_t s, input int gmin, input int gmax,
                          input int poke_at, input bit lat);
    int t;
    model(s);
    obs_q.delete();
    pulse_start();
    for (int k = 0; k < s.size(); k++)
      send_byte(s[k], $urandom_range(gmax, gmin), k == poke_at);
    if (lat) begin
      check({tag, "_lat_we"}, 32'(bus.im_we), 32'd1);
      check({tag, "_lat_addr"}, 32'(bus.im_addr), 32'd0);
      check({tag, "_lat_data"}, bus.im_wdata, 32'hDEADBEEF);
      @(negedge clk);
      check({tag, "_lat_done"}, 32'(done), 32'd1);
      check({tag, "_lat_we_off"}, 32'(bus.im_we), 32'd0);
    end
    t = 0;
    while (done !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, 32'(t < 50), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_word_cnt"}, 32'(word_cnt), 32'(exp_cnt));
    check({tag, "_n_writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_addr"}, 32'(obs_q[i][41:32]), 32'(exp_q[i][41:32]));
      check({tag, "_data"}, obs_q[i][31:0], exp_q[i][31:0]);
    end
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_cnt_hold"}, 32'(word_cnt), 32'(exp_cnt));
    if (exp_q.size() > 0) begin
      check({tag, "_addr_hold"}, 32'(bus.im_addr), 32'(exp_q[exp_q.size()-1][41:32]));
      check({tag, "_data_hold"}, bus.im_wdata, exp_q[exp_q.size()-1][31:0]);
    end
  endtask

  initial begin
    bq_t s, r;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_we", 32'(bus.im_we), 32'd0);
    check("rst_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);
    check("rst_addr", 32'(bus.im_addr), 32'd0);
    check("rst_wdata", bus.im_wdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single word DEADBEEF, with cycle-exact latency when no checksum byte
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_chk(s, 1'b0, r);
`ifdef IM_LOADER_CHECKSUM_EN
    run_load("one_word", r, 0, 0, -1, 1'b0);
`else
    run_load("one_word", r, 0, 0, -1, 1'b1);
`endif

    // Three words, rx_valid low every other cycle
    build(3, 1'b0, r);
    run_load("toggle3", r, 1, 1, -1, 1'b0);

    // Length errors: zero and one past capacity
    s = '{8'h00, 8'h00};
    run_load("len_zero", s, 0, 0, -1, 1'b0);
    s = '{8'h04, 8'h01};
    run_load("len_over", s, 0, 0, -1, 1'b0);

    // Reset after 2 of 3 words
    build(3, 1'b0, r);
    model(r);
    obs_q.delete();
    pulse_start();
    for (int k = 0; k < 10; k++) send_byte(r[k], 0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_we", 32'(bus.im_we), 32'd0);
    check("mid_rst_ready", 32'(bus.rx_ready), 32'd0);
    check("mid_rst_cnt", 32'(word_cnt), 32'd0);
    check("mid_rst_n_writes", 32'(obs_q.size()), 32'd2);
    for (int i = 0; i < 2 && i < obs_q.size(); i++)
      check("mid_rst_data", obs_q[i][31:0], exp_q[i][31:0]);
    repeat (2) @(negedge clk);
    check("mid_rst_no_we", 32'(obs_q.size()), 32'd2);
    reset_n = 1'b1;
    @(negedge clk);
    build(2, 1'b0, r);
    run_load("after_rst", r, 0, 2, -1, 1'b0);

    // Start pulsed mid-load is ignored
    build(4, 1'b0, r);
    run_load("start_mid", r, 0, 1, 5, 1'b0);

    // Randomised loads
    for (int i = 0; i < 6; i++) begin
      build(int'($urandom_range(6, 1)), 1'b0, r);
      run_load("rand", r, 0, 3, -1, 1'b0);
    end

    // Full-capacity load
    build(TB_MAX - TB_BASE, 1'b0, r);
    run_load("full", r, 0, 0, -1, 1'b0);

`ifdef IM_LOADER_CHECKSUM_EN
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_load("chk_good", s, 0, 0, -1, 1'b0);
    check("chk_good_err", 32'(err), 32'd0);
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    run_load("chk_bad", s, 0, 0, -1, 1'b0);
    check("chk_bad_err", 32'(err), 32'd1);
    build(3, 1'b1, r);
    run_load("chk_rand_bad", r, 0, 2, -1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0, first IM word index written.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, IM depth in words.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a load.
REQ-006 SHALL have port rx_data  in  8  inbound program byte.
REQ-007 SHALL have port rx_valid  in  1  rx_data valid.
REQ-008 SHALL have port rx_ready  out  1  loader accepts the byte this cycle.
REQ-009 SHALL have port im_we  out  1  IM write strobe.
REQ-010 SHALL have port im_addr  out  10  IM word address.
REQ-011 SHALL have port im_wdata  out  32  IM write word.
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.
REQ-013 SHALL have port done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port err  out  1  sticky error, cleared by the next accepted start.
REQ-015 SHALL have port word_cnt  out  11  words written this load.

Function
REQ-016 SHALL transfer a byte only on a cycle where rx_valid and rx_ready are both high.
REQ-017 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE.
REQ-018 SHALL hold rx_ready high in LEN_HI, LEN_LO, DATA and CHK, and low in IDLE, WRITE and DONE.
REQ-019 SHALL move from IDLE to LEN_HI on start, clearing err, word_cnt and the byte index.
REQ-020 SHALL ignore start when not in IDLE.
REQ-021 SHALL take the word count N as the byte in LEN_HI (high) and the byte in LEN_LO (low).
REQ-022 SHALL go to DONE with err=1 when N==0 or N > MAX_WORDS-BASE_ADDR, writing nothing.
REQ-023 SHALL assemble each word in DATA from 4 bytes, most significant byte first.
REQ-024 SHALL go to WRITE on the 4th byte; in WRITE, im_we=1 for exactly one cycle with im_addr=BASE_ADDR+word_cnt and im_wdata=the assembled word.
REQ-025 SHALL increment word_cnt in WRITE, then go to DATA if word_cnt<N, else to CHK (macro defined) or DONE.
REQ-026 SHALL give latency of last-byte handshake at cycle t -> im_we at t+1 -> done at t+2 (no checksum).
REQ-027 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-028 SHALL keep im_we low in every state other than WRITE.
REQ-029 SHALL hold im_addr and im_wdata at their last values when im_we is low.
REQ-030 SHALL hold word_cnt after DONE until the next accepted start.
REQ-031 SHALL leave bytes held off (rx_valid low) without effect on state; the byte index is preserved.

Reset
REQ-032 SHALL, on reset_n low, enter IDLE immediately.
REQ-033 SHALL reset rx_ready, im_we, busy, done and err to 0, and im_addr, im_wdata and word_cnt to 0.
REQ-034 SHALL, on reset mid-load, abandon the load without further writes; words already written are not rolled back.

Configuration
REQ-035 SHALL, with IM_LOADER_CHECKSUM_EN defined, accept one CHK byte after the last word and set err=1 if it differs from the XOR of all data bytes; DONE follows either way.
REQ-036 SHALL, with IM_LOADER_CHECKSUM_EN undefined, omit the CHK state and checksum logic; err arises only from REQ-022.

Structure
REQ-037 SHALL place the state enum, IM_ADDR_W=10, BYTE_W=8 and the MAX_WORDS default in package im_loader_pkg.
REQ-038 SHALL place byte-to-word packing (shift register plus 2-bit byte index) in sub-module im_byte_packer.

Verification
REQ-039 SHALL check: start; bytes 00 01 DE AD BE EF -> one im_we at im_addr 0, im_wdata DEADBEEF, done next cycle, word_cnt 1, err 0.
REQ-040 SHALL check: N=3 with rx_valid toggling every other cycle -> writes at addresses 0,1,2 in order with correct words, no extra im_we.
REQ-041 SHALL check: length bytes 00 00, and separately 04 01 with BASE_ADDR 0 -> no im_we, done pulse, err 1.
REQ-042 SHALL check: reset_n low after 2 of 3 words -> IDLE, im_we 0, busy 0; a fresh load then succeeds.
REQ-043 SHALL check, with checksum enabled: data 12345678 with CHK 08 -> err 0; with CHK 09 -> err 1, word still written.
REQ-044 SHALL check: start pulsed mid-load -> ignored, load completes unchanged.
